// File: rtl/shift_register8_pkg.sv
// Shared sizing constants for the FFT sample-buffer blocks.
package shift_register8_pkg;

  localparam int unsigned WIDTH_DEF = 10;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned SEL_W     = 3;

endpackage

// File: rtl/sr8_stage.sv
// One complex sample register with enable and async active-low clear.
module sr8_stage #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d_re,
  input  logic [WIDTH-1:0] d_im,
  output logic [WIDTH-1:0] q_re,
  output logic [WIDTH-1:0] q_im
);

  logic [WIDTH-1:0] re_d, re_q;
  logic [WIDTH-1:0] im_d, im_q;

  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (en) begin
      re_d = d_re;
      im_d = d_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= '0;
      im_q <= '0;
    end else begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign q_re = re_q;
  assign q_im = im_q;

endmodule

// File: rtl/shift_register8.sv
// 8-deep complex sample shift register; new samples enter at s[7], s[0] is oldest.
// Read tap is a combinational 8:1 mux on sel.
module shift_register8
  import shift_register8_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ren,
  input  logic [WIDTH-1:0] dinre,
  input  logic [WIDTH-1:0] dinim,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] doutre,
  output logic [WIDTH-1:0] doutim
);

  logic [WIDTH-1:0] s_re [DEPTH];
  logic [WIDTH-1:0] s_im [DEPTH];

  // Stage k takes from stage k+1; the last stage takes the input sample.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == DEPTH - 1) begin : g_head
      sr8_stage #(.WIDTH(WIDTH)) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ren),
        .d_re (dinre),
        .d_im (dinim),
        .q_re (s_re[k]),
        .q_im (s_im[k])
      );
    end else begin : g_body
      sr8_stage #(.WIDTH(WIDTH)) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ren),
        .d_re (s_re[k+1]),
        .d_im (s_im[k+1]),
        .q_re (s_re[k]),
        .q_im (s_im[k])
      );
    end
  end

  always_comb begin
    doutre = s_re[sel];
    doutim = s_im[sel];
  end

endmodule

// File: tb/tb_shift_register8.sv
// Directed and random checks of shift_register8 against a queue-based sample model.
`timescale 1ns/100ps
module tb_shift_register8;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ren;
  logic [W-1:0] dinre, dinim;
  logic [2:0]   sel;
  logic [W-1:0] doutre, doutim;

  int total = 0;
  int bad   = 0;

  // Model: the 8 most recent samples, oldest at index 0.
  logic [W-1:0] m_re[$];
  logic [W-1:0] m_im[$];

  shift_register8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ren   (ren),
    .dinre (dinre),
    .dinim (dinim),
    .sel   (sel),
    .doutre(doutre),
    .doutim(doutim)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_re.delete();
    m_im.delete();
    for (int i = 0; i < 8; i++) begin
      m_re.push_back('0);
      m_im.push_back('0);
    end
  endtask

  task automatic model_push(input logic [W-1:0] re, input logic [W-1:0] im);
    m_re.push_back(re);
    m_im.push_back(im);
    void'(m_re.pop_front());
    void'(m_im.pop_front());
  endtask

  // Sweep every tap against the model; takes 8 ns, caller keeps it clear of clock edges.
  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #1;
      chk($sformatf("%s_re%0d", tag, i), doutre, m_re[i]);
      chk($sformatf("%s_im%0d", tag, i), doutim, m_im[i]);
    end
  endtask

  task automatic do_shift(input logic [W-1:0] re, input logic [W-1:0] im);
    @(negedge clk);
    ren   = 1'b1;
    dinre = re;
    dinim = im;
    @(posedge clk);
    model_push(re, im);
    #1;
    ren = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    sweep("rst_pulse");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] r_re, r_im;
    logic         r_en;

    rst_n = 1'b0;
    ren   = 1'b0;
    dinre = '0;
    dinim = '0;
    sel   = '0;
    model_clear();

    // Asynchronous reset with no clock edge yet.
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #0.5;
      chk($sformatf("por_re%0d", i), doutre, 10'd0);
      chk($sformatf("por_im%0d", i), doutim, 10'd0);
    end
    #2;
    rst_n = 1'b1;

    // Partial fill: unfilled taps read zero.
    do_shift(10'd5, 10'd6);
    @(negedge clk);
    sweep("partial");
    sel = 3'd6;
    #0.1;
    chk("partial_s6_zero", doutre, 10'd0);
    pulse_reset();

    // Fill 0..7 and read back in order.
    for (int i = 0; i < 8; i++) do_shift(W'(i), 10'd0);
    @(negedge clk);
    sweep("fill");
    sel = 3'd7;
    #0.1;
    chk("fill_s7", doutre, 10'd7);

    // Hold: ren low, inputs toggling.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dinre = W'($urandom);
      dinim = W'($urandom);
    end
    @(negedge clk);
    sel = 3'd3;
    #1;
    chk("hold_s3", doutre, 10'd3);
    sweep("hold");

    // Overflow: 10 shifts keep only the last 8.
    pulse_reset();
    for (int i = 0; i < 10; i++) do_shift(W'(i), W'(i + 100));
    @(negedge clk);
    sel = 3'd0;
    #1;
    chk("ovf_s0", doutre, 10'd2);
    sel = 3'd7;
    #1;
    chk("ovf_s7", doutre, 10'd9);
    sweep("ovf");

    // Lockstep / sign pass-through.
    pulse_reset();
    do_shift(10'h3FF, 10'h155);
    @(negedge clk);
    sel = 3'd7;
    #1;
    chk("sign_s7_re", doutre, 10'h3FF);
    chk("sign_s7_im", doutim, 10'h155);
    sel = 3'd6;
    #1;
    chk("sign_s6_re", doutre, 10'd0);
    chk("sign_s6_im", doutim, 10'd0);

    // Mid-fill reset, then a clean refill.
    pulse_reset();
    for (int i = 0; i < 4; i++) do_shift(W'(i + 20), W'(i + 40));
    pulse_reset();
    for (int i = 0; i < 8; i++) do_shift(W'(i), 10'd0);
    @(negedge clk);
    sweep("refill");

    // Random enables, data and taps.
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      r_en  = 1'($urandom);
      r_re  = W'($urandom);
      r_im  = W'($urandom);
      ren   = r_en;
      dinre = r_re;
      dinim = r_im;
      sel   = 3'($urandom_range(0, 7));
      #1;
      chk("rnd_pre_re", doutre, m_re[sel]);
      chk("rnd_pre_im", doutim, m_im[sel]);
      @(posedge clk);
      if (r_en) model_push(r_re, r_im);
      #1;
      ren = 1'b0;
      chk("rnd_post_re", doutre, m_re[sel]);
      chk("rnd_post_im", doutim, m_im[sel]);
    end
    @(negedge clk);
    sweep("rnd_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_register8.md
SHIFT_REGISTER8 -- requirements
Module: shift_register8

Interface
- REQ-001 Parameter WIDTH, default 10, is the bit width of each real/imaginary sample component.
- REQ-002 The port list SHALL be one clock and one asynchronous active-low reset, named clk and rst_n.
- REQ-003 clk  input  1  rising-edge clock for all storage.
- REQ-004 rst_n  input  1  asynchronous active-low reset.
- REQ-005 ren  input  1  shift enable; when high, the sample on dinre/dinim is captured at the clock edge.
- REQ-006 dinre  input  WIDTH  real part of the input sample (two's complement, passed through unmodified).
- REQ-007 dinim  input  WIDTH  imaginary part of the input sample.
- REQ-008 sel  input  3  read-tap select, 0..7.
- REQ-009 doutre  output  WIDTH  real part of the selected stored sample.
- REQ-010 doutim  output  WIDTH  imaginary part of the selected stored sample.

Function
- REQ-011 The block SHALL hold exactly 8 complex entries, s[0]..s[7], each WIDTH bits real plus WIDTH bits imaginary.
- REQ-012 On a rising clk edge with ren=1, s[k] SHALL load s[k+1] for k=0..6, and s[7] SHALL load {dinre,dinim}.
- REQ-013 On a rising clk edge with ren=0, all entries SHALL hold their values; the block has no wrap-around or recirculation.
- REQ-014 The output SHALL be combinational from sel: doutre/doutim = s[sel] real/imag, with zero-cycle latency from sel and one-cycle latency from a write.
- REQ-015 After 8 consecutive enabled shifts of samples x0..x7, sel=i SHALL return xi (sel=0 is the oldest, sel=7 is the newest).
- REQ-016 With fewer than 8 shifts since reset, un-filled entries SHALL read as 0.
- REQ-017 More than 8 consecutive shifts SHALL discard the oldest samples; the block has no full/overflow flag.
- REQ-018 Real and imaginary paths SHALL shift in lockstep; no arithmetic, rounding or sign change SHALL be applied.
- REQ-019 Changing sel while ren=1 SHALL be legal; the output reflects the pre-edge contents until the edge, then the shifted contents.

Reset
- REQ-020 rst_n=0 SHALL clear all 16 registers to 0 immediately, without waiting for a clock edge, so doutre=doutim=0 for any sel.
- REQ-021 rst_n=0 SHALL dominate ren; a reset asserted mid-fill SHALL discard all stored samples.
- REQ-022 After rst_n deasserts, the first enabled edge SHALL write s[7].

Structure
- REQ-023 A shared package SHALL hold the WIDTH default (10), the DEPTH constant (8) and the SEL_W constant (3), for reuse by the other FFT blocks.
- REQ-024 One sub-module, sr8_stage, is natural: one complex register with async reset and enable, instantiated 8 times in a chain; the 8:1 output mux SHALL stay in the top level.
- REQ-025 The design SHALL contain no latches; the output mux SHALL cover all 8 sel values.

Verification
- REQ-026 Reset check: assert rst_n=0 for 6 ns with no clock edge required -> doutre=doutim=0 for all sel 0..7.
- REQ-027 Fill and read: ren=1 and dinre=0..7 on 8 consecutive edges with dinim=0, then ren=0 and sweep sel 0..7 -> doutre=0,1,...,7 and doutim=0.
- REQ-028 Hold check: with ren=0 and dinre toggling randomly for 10 cycles -> contents are unchanged, and sel=3 still reads 3.
- REQ-029 Overflow check: shift 10 samples 0..9 -> sel=0 reads 2 and sel=7 reads 9.
- REQ-030 Lockstep and sign check: dinre=-1 (0x3FF) and dinim=0x155 shifted once -> sel=7 gives doutre=0x3FF and doutim=0x155, and sel=6 gives 0/0.
- REQ-031 Mid-operation reset: pulse rst_n low between edges after 4 shifts -> outputs read 0 immediately, and a subsequent fill behaves as in REQ-027.
